// File: rtl/if_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
// FETCH_PREFETCH_EN selects the two-entry prefetching buffer.
package if_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic               RstEnable = 1'b1;
  localparam logic               Stop      = 1'b1;
  localparam logic               NoStop    = 1'b0;
  localparam logic [InstBus-1:0] ZeroWord  = '0;

`ifdef FETCH_PREFETCH_EN
  localparam bit PrefetchEn = 1'b1;
`else
  localparam bit PrefetchEn = 1'b0;
`endif

  localparam int unsigned BufDepth = PrefetchEn ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_inst_buf.sv
// In-order pc+inst buffer between the fetch FSM and IF/ID; Depth is 1 or 2.
// Pop is applied before push, so a full buffer can be popped and refilled in one cycle.
module if_inst_buf
  import if_fetch_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [InstAddrBus-1:0] push_pc_i,
  input  logic [InstBus-1:0]     push_inst_i,
  input  logic                   pop_i,
  output logic                   head_valid_o,
  output logic                   full_o,
  output logic [InstAddrBus-1:0] head_pc_o,
  output logic [InstBus-1:0]     head_inst_o
);

  logic [Depth-1:0]       valid_d, valid_q;
  logic [InstAddrBus-1:0] pc_d   [Depth];
  logic [InstAddrBus-1:0] pc_q   [Depth];
  logic [InstBus-1:0]     inst_d [Depth];
  logic [InstBus-1:0]     inst_q [Depth];
  logic                   placed;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    placed  = 1'b0;
    if (clear_i) begin
      valid_d = '0;
    end else begin
      if (pop_i) begin
        for (int i = 0; i < Depth - 1; i++) begin
          valid_d[i] = valid_q[i+1];
          pc_d[i]    = pc_q[i+1];
          inst_d[i]  = inst_q[i+1];
        end
        valid_d[Depth-1] = 1'b0;
      end
      if (push_i) begin
        for (int i = 0; i < Depth; i++) begin
          if (!valid_d[i] && !placed) begin
            valid_d[i] = 1'b1;
            pc_d[i]    = push_pc_i;
            inst_d[i]  = push_inst_i;
            placed     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign head_valid_o = valid_q[0];
  assign full_o       = &valid_q;
  assign head_pc_o    = pc_q[0];
  assign head_inst_o  = inst_q[0];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, handshakes with instruction memory and feeds IF/ID.
// Define FETCH_PREFETCH_EN for a second buffer entry with a prefetch request issued in S_HOLD.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned            PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  input  logic                   flush_i,
  input  logic [InstAddrBus-1:0] new_pc_i,
  output logic                   inst_req_o,
  output logic [InstAddrBus-1:0] inst_addr_o,
  input  logic                   inst_ack_i,
  input  logic [InstBus-1:0]     inst_rdata_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   stallreq_o
);

  fetch_state_e           state_d, state_q;
  logic [InstAddrBus-1:0] pc_d, pc_q;
  logic [InstAddrBus-1:0] tgt_d, tgt_q;
  logic [InstAddrBus-1:0] pc_next, fetch_addr, redirect;
  logic                   buf_push, buf_pop, buf_clear;
  logic                   buf_valid, buf_full;
  logic [InstAddrBus-1:0] buf_pc;
  logic [InstBus-1:0]     buf_inst;
  logic                   pf_req, pf_ack;
  logic [4:0]             unused_stall;

  assign unused_stall = stall[5:1];
  assign pc_next      = pc_q + InstAddrBus'(PC_STEP);
  assign pf_req       = PrefetchEn && (state_q == S_HOLD) && !buf_full;
  assign pf_ack       = pf_req && inst_ack_i;
  assign fetch_addr   = (state_q == S_HOLD) ? pc_next : pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    redirect  = flush_i ? new_pc_i : branch_target_i;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    buf_clear = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (flush_i) pc_d = new_pc_i;
      end
      S_REQ: begin
        if (flush_i) begin
          if (inst_ack_i) begin
            pc_d = new_pc_i;
          end else begin
            tgt_d   = new_pc_i;
            state_d = S_DROP;
          end
        end else if (inst_ack_i) begin
          buf_push = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush_i || (stall[0] == NoStop && branch_flag_i)) begin
          buf_clear = 1'b1;
          // An unfinished prefetch must complete before the redirect target is requested.
          if (pf_req && !inst_ack_i) begin
            pc_d    = pc_next;
            tgt_d   = redirect;
            state_d = S_DROP;
          end else begin
            pc_d    = redirect;
            state_d = S_REQ;
          end
        end else if (stall[0] == NoStop) begin
          buf_pop  = 1'b1;
          buf_push = pf_ack;
          pc_d     = pc_next;
          if (!(PrefetchEn && buf_full) && !pf_ack) state_d = S_REQ;
        end else if (stall[0] == Stop) begin
          buf_push = pf_ack;
        end
      end
      S_DROP: begin
        if (flush_i) tgt_d = new_pc_i;
        if (inst_ack_i) begin
          pc_d    = flush_i ? new_pc_i : tgt_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  if_inst_buf #(
    .Depth (BufDepth)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (buf_clear),
    .push_i       (buf_push),
    .push_pc_i    (fetch_addr),
    .push_inst_i  (inst_rdata_i),
    .pop_i        (buf_pop),
    .head_valid_o (buf_valid),
    .full_o       (buf_full),
    .head_pc_o    (buf_pc),
    .head_inst_o  (buf_inst)
  );

  always_comb begin
    inst_req_o  = (state_q == S_REQ) || (state_q == S_DROP) || pf_req;
    inst_addr_o = inst_req_o ? fetch_addr : ZeroWord;
    pc_o        = buf_valid ? buf_pc : ZeroWord;
    inst_o      = buf_valid ? buf_inst : ZeroWord;
    stallreq_o  = !buf_valid || (state_q == S_DROP);
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: cycle table from reset, directed corner sequences,
// then randomized traffic against an architectural PC-stream model.
module tb_if_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  if_fetch #(
    .RESET_PC (RstPc),
    .PC_STEP  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_ack_i      (inst_ack_i),
    .inst_rdata_i    (inst_rdata_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .stallreq_o      (stallreq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        s0;
    logic        ack;
    logic        br;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic s0, ack, br, input logic [31:0] tgt, input logic fl,
                              input logic [31:0] npc, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc);
    vec_t r;
    r.s0 = s0; r.ack = ack; r.br = br; r.tgt = tgt; r.fl = fl; r.npc = npc;
    r.req = req; r.addr = addr; r.v = v; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 6'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    flush_i = 1'b0; new_pc_i = 32'h0; inst_ack_i = 1'b0; inst_rdata_i = 32'h0;
  endtask

  // Leaves the bench one tick into the first post-reset cycle (DUT in its idle cycle).
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] exp_pc, pend_addr;
  logic        pend;
  int          waited, lat, consumed;
  vec_t        cv;

  initial begin
    // Cycle table starting in the idle cycle after reset.
    //                 s0 ack br tgt        fl npc        req addr       v  pc
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h8));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h8));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'hC,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'hC,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h10));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 32'h200, 0, 32'h0,   0, 32'h0,   1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h100));
    vecs.push_back(mk(0, 0, 1, 32'h300, 0, 32'h0,   1, 32'h104, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h104, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 32'h180, 1, 32'h108, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h108, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 32'h1C0, 1, 32'h108, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h108, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h1C0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h500, 1, 32'h40,  0, 32'h0,   1, 32'h1C0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, 32'h80,  1, 32'h40,  0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h84,  0, 32'h0));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      cv = vecs[i];
      stall           = cv.s0 ? 6'b000011 : 6'b000000;
      branch_flag_i   = cv.br;
      branch_target_i = cv.tgt;
      flush_i         = cv.fl;
      new_pc_i        = cv.npc;
      inst_ack_i      = cv.ack;
      inst_rdata_i    = cv.ack ? mem(inst_addr_o) : 32'h0;
      #1;
      chk1($sformatf("v%0d_req", i), inst_req_o, cv.req);
      chk($sformatf("v%0d_addr", i), inst_addr_o, cv.addr);
      chk($sformatf("v%0d_pc", i), pc_o, cv.v ? cv.pc : 32'h0);
      chk($sformatf("v%0d_inst", i), inst_o, cv.v ? mem(cv.pc) : 32'h0);
      chk1($sformatf("v%0d_stallreq", i), stallreq_o, !cv.v);
      tick();
    end

    // Asynchronous reset in the middle of an outstanding request.
    idle_inputs();
    chk1("pre_rst_req", inst_req_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("arst_req", inst_req_o, 1'b0);
    chk("arst_addr", inst_addr_o, 32'h0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_inst", inst_o, 32'h0);
    chk1("arst_stallreq", stallreq_o, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk1("post_rst_idle_req", inst_req_o, 1'b0);
    tick();
    chk1("post_rst_req", inst_req_o, 1'b1);
    chk("post_rst_addr", inst_addr_o, RstPc);

    // PC wrap: 0xFFFF_FFFC consumed -> next fetch at 0.
    flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
    inst_ack_i = 1'b1; inst_rdata_i = mem(inst_addr_o);
    tick();
    flush_i = 1'b0;
    chk("wrap_req_addr", inst_addr_o, 32'hFFFF_FFFC);
    inst_rdata_i = mem(inst_addr_o);
    tick();
    inst_ack_i = 1'b0;
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_inst", inst_o, mem(32'hFFFF_FFFC));
    tick();
    chk1("wrap_next_req", inst_req_o, 1'b1);
    chk("wrap_next_addr", inst_addr_o, 32'h0);

    // Flush while a request to 0x20 waits several cycles for its ack.
    flush_i = 1'b1; new_pc_i = 32'h20; inst_ack_i = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drop%0d_addr", k), inst_addr_o, 32'h20);
      chk1($sformatf("drop%0d_req", k), inst_req_o, 1'b1);
      chk1($sformatf("drop%0d_stallreq", k), stallreq_o, 1'b1);
      flush_i      = (k == 0);
      new_pc_i     = 32'h180;
      inst_ack_i   = (k == 4);
      inst_rdata_i = mem(32'h20);
      tick();
    end
    flush_i = 1'b0; inst_ack_i = 1'b0;
    chk1("redir_req", inst_req_o, 1'b1);
    chk("redir_addr", inst_addr_o, 32'h180);
    chk1("redir_stallreq", stallreq_o, 1'b1);
    inst_ack_i = 1'b1; inst_rdata_i = mem(32'h180);
    tick();
    inst_ack_i = 1'b0; stall = 6'b000011;
    chk("redir_pc", pc_o, 32'h180);
    chk("redir_inst", inst_o, mem(32'h180));
    chk1("redir_stallreq_low", stallreq_o, 1'b0);

    // Randomized traffic: model tracks the architectural PC stream only.
    do_reset();
    exp_pc = RstPc; pend = 1'b0; pend_addr = 32'h0;
    waited = 0; lat = $urandom_range(0, 3); consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pend) begin
        chk1("held_req", inst_req_o, 1'b1);
        chk("held_addr", inst_addr_o, pend_addr);
      end
      if (stallreq_o) begin
        chk("bubble_pc", pc_o, 32'h0);
        chk("bubble_inst", inst_o, 32'h0);
      end
      stall           = 6'($urandom);
      stall[0]        = ($urandom_range(0, 2) == 0);
      branch_flag_i   = ($urandom_range(0, 3) == 0);
      branch_target_i = 32'($urandom_range(0, 1023)) << 2;
      flush_i         = ($urandom_range(0, 24) == 0);
      new_pc_i        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                                    : 32'($urandom_range(0, 1023)) << 2;
      inst_ack_i      = 1'b0;
      inst_rdata_i    = $urandom;
      if (inst_req_o) begin
        if (waited >= lat) begin
          inst_ack_i   = 1'b1;
          inst_rdata_i = mem(inst_addr_o);
          waited       = 0;
          lat          = $urandom_range(0, 3);
        end else begin
          waited++;
        end
      end
      if (flush_i) begin
        exp_pc = new_pc_i;
      end else if (!stallreq_o && !stall[0]) begin
        chk("rand_pc", pc_o, exp_pc);
        chk("rand_inst", inst_o, mem(exp_pc));
        consumed++;
        exp_pc = branch_flag_i ? branch_target_i : exp_pc + 32'd4;
      end
      pend      = inst_req_o && !inst_ack_i;
      pend_addr = inst_addr_o;
      tick();
    end
    chk1("rand_progress", consumed > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
